// File: rtl/rr_engine_arbiter.sv
// rtl/rr_engine_arbiter.sv - round-robin arbiter sharing one start/ready engine among NREQ requesters
// Optional concurrent assertions are compiled in with `define RR_ARB_ASSERT_EN.
module rr_engine_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     eng_start,
    output logic [DW-1:0]            eng_data,
    input  logic                     eng_busy,
    input  logic                     eng_ready,
    output logic                     timeout_err,
    output logic [$clog2(NREQ)-1:0]  active_id
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   slot [NREQ];
    logic [IW-1:0]   win;
    logic            found;
    logic [IW:0]     pos;
    logic [IW-1:0]   nxt;

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign slot[g] = req_data[g*DW +: DW];
    end

    // First set request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
            if (!found && req[pos[IW-1:0]]) begin
                found = 1'b1;
                win   = pos[IW-1:0];
            end
        end
    end

    assign nxt = (active_id == IW'(NREQ-1)) ? '0 : active_id + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            gnt         <= '0;
            done        <= '0;
            eng_start   <= 1'b0;
            eng_data    <= '0;
            timeout_err <= 1'b0;
            active_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done        <= '0;
                    timeout_err <= 1'b0;
                    gnt         <= '0;
                    if (found) begin
                        active_id <= win;
                        eng_data  <= slot[win];
                        gnt       <= NREQ'(1) << win;
                        eng_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    eng_start <= 1'b0;
                    cnt       <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    // A ready arriving on the last allowed cycle still completes normally.
                    if (eng_ready) begin
                        done  <= NREQ'(1) << active_id;
                        state <= DONE;
                    end else if (cnt == CW'(TIMEOUT-1)) begin
                        timeout_err <= 1'b1;
                        gnt         <= '0;
                        ptr         <= nxt;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    ptr   <= nxt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RR_ARB_ASSERT_EN
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt))
        else $error("a_gnt_onehot");
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(done))
        else $error("a_done_onehot");
    a_done_gnt: assert property (@(posedge clk) disable iff (!rst) (|done) |-> gnt == done)
        else $error("a_done_gnt");
    a_start_busy: assert property (@(posedge clk) disable iff (!rst) eng_start |=> ##[0:2] eng_busy)
        else $error("a_start_busy");
    a_start_pulse: assert property (@(posedge clk) disable iff (!rst) eng_start |=> !eng_start)
        else $error("a_start_pulse");
    a_timeout_no_done: assert property (@(posedge clk) disable iff (!rst) timeout_err |-> done == '0)
        else $error("a_timeout_no_done");
    for (genvar i = 0; i < NREQ; i++) begin : g_fair
        a_fair: assert property (@(posedge clk) disable iff (!rst)
            req[i] && !gnt[i] && (state == IDLE) && (ptr == IW'(i)) |=> gnt[i])
            else $error("a_fair");
    end
`else
    logic unused_busy;
    assign unused_busy = eng_busy;
`endif

endmodule
